simd_issue_ctrl: RTL and testbench
==================================

# simd_issue_ctrl

Issue-side controller for the packed-SIMD execution unit. It accepts one decoded SIMD instruction at a time from the core and drives the unit's `ctrl`/`a`/`b`/`valid_in` interface. It holds the operands stable until the unit pulses `valid_out`, then returns the result to the core's writeback port. It guards against a hung unit with a timeout that latches a fault.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum cycles spent in WAIT before declaring a fault; legal range 8..255.

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low. One clock; the reset is asynchronous and active-low.
- `op_valid`, input, 1: core presents an instruction.
- `op_ready`, output, 1: controller can accept; high only in IDLE.
- `op_funct`, input, 2: 00 PVADD, 01 PVMUL, 10 PVMAC, 11 PVMUL_UPPER.
- `op_rs1`, input, 32: operand A.
- `op_rs2`, input, 32: operand B.
- `op_rd`, input, 5: destination register.
- `vu_ctrl`, output, 2: to unit `ctrl`.
- `vu_a`, output, 32: to unit `a`.
- `vu_b`, output, 32: to unit `b`.
- `vu_valid_in`, output, 1: to unit `valid_in`; single-cycle pulse.
- `vu_valid_out`, input, 1: from unit `valid_out`.
- `vu_result`, input, 32: from unit `result`.
- `wb_valid`, output, 1: writeback data available.
- `wb_ready`, input, 1: core accepts writeback.
- `wb_rd`, output, 5: destination register.
- `wb_data`, output, 32: result.
- `wb_err`, output, 1: writeback is a timeout error; `wb_data` is 0.
- `fault`, output, 1: sticky; set on timeout, cleared only by reset.
- `done_cnt`, output, 16: successful completions, saturating at 0xFFFF.

## Operation

FSM states: IDLE, ISSUE, WAIT, RESP, FAULT.

- **IDLE**
  - `op_ready`=1.
  - On `op_valid`: latch funct, rs1, rs2 and rd into the issue registers; go to ISSUE.
- **ISSUE**
  - `vu_valid_in`=1 for exactly this cycle.
  - Clear the wait timer; go to WAIT.
- **WAIT**
  - Timer increments each cycle.
  - On `vu_valid_out`=1:
    - Capture `vu_result` into `wb_data`, set `wb_err`=0, increment `done_cnt`.
    - If rd≠0 go to RESP; if rd=0 go to IDLE and produce no writeback.
  - Timeout: if the timer equals TIMEOUT−1 and `vu_valid_out`=0, set `wb_data`=0, `wb_err`=1, `fault`=1, and go to RESP.
  - If `vu_valid_out` and the timeout coincide, `vu_valid_out` wins.
- **RESP**
  - `wb_valid`=1 while in RESP.
  - `wb_rd`, `wb_data` and `wb_err` are held stable until `wb_valid && wb_ready`.
  - On that handshake: go to IDLE, or to FAULT if `wb_err`=1.
- **FAULT**
  - `op_ready`=0; all unit outputs are 0.
  - No exit except reset.

Operand rules:
- `vu_ctrl`, `vu_a` and `vu_b` are driven from the issue registers. They must stay constant from ISSUE through the cycle in which `vu_valid_out` is sampled, because the unit reads them combinationally throughout its computation.
- The issue registers update only on the IDLE accept.

Counter rules:
- `done_cnt` is not incremented on a timeout.
- `done_cnt` holds at 0xFFFF once saturated.

## Timing

- Reset values:
  - state IDLE.
  - `op_ready`=1.
  - `vu_ctrl`=0, `vu_a`=0, `vu_b`=0, `vu_valid_in`=0.
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `wb_err`=0.
  - `fault`=0, `done_cnt`=0.
- Reset mid-operation aborts immediately to these values. The unit shares `rst_n` and resets together with the controller.
- Cycle numbering: accept in cycle T, `vu_valid_in` in cycle T+1.
- Unit response, counted from `vu_valid_in` in cycle I:

  | Op | `vu_valid_out` cycle |
  |---|---|
  | PVADD | I+2 |
  | PVMUL | I+5 |
  | PVMUL_UPPER | I+5 |
  | PVMAC | I+6 |

- Resulting `wb_valid` cycle (with `wb_ready` held high):

  | Op | `wb_valid` cycle |
  |---|---|
  | PVADD | T+4 |
  | PVMUL | T+7 |
  | PVMUL_UPPER | T+7 |
  | PVMAC | T+8 |

- Next accept is possible in the cycle after the writeback handshake.
- `vu_valid_out` deasserts one cycle after it is captured. The controller never asserts `vu_valid_in` within 2 cycles of a capture, so back-to-back issues never collide with a stale `vu_valid_out`.
- `vu_valid_out` outside WAIT is ignored.
- `op_valid` outside IDLE is ignored; `op_ready`=0 there.
- A timeout produces `wb_valid` in cycle T+2+TIMEOUT.

## Test plan

- **PVADD:** rs1=0x7F01FF80, rs2=0x01010180, rd=5 → `vu_valid_in` pulse at T+1; at T+4 `wb_valid`=1, `wb_data`=0x80020000, `wb_rd`=5, `wb_err`=0; `done_cnt`=1.
- **PVMUL:** rs1=0x0000FE03, rs2=0x00000504 → `wb_data`=0xFFF6000C at T+7. Check `vu_a`/`vu_b`/`vu_ctrl` are constant through WAIT.
- **PVMAC:** rs1=0x01020304, rs2=0x01010101 → `wb_data`=0x0000000A at T+8.
- **Backpressure:** hold `wb_ready`=0 for 5 cycles after `wb_valid` → `wb_*` stable, `op_ready`=0, a new `op_valid` is ignored. Release → IDLE next cycle; the following op accepts normally.
- **rd=0:** PVADD with rd=0 → no `wb_valid`; `done_cnt` increments; `op_ready`=1 at T+4.
- **Timeout:** model unit with `vu_valid_out` tied low, TIMEOUT=16 → `wb_valid` at T+18 with `wb_err`=1 and `wb_data`=0; after the handshake `fault`=1 and `op_ready`=0 permanently. Assert `rst_n` low → all outputs return to their reset values.

Source files
------------

// File: rtl/simd_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// simd_issue_ctrl_if
//   Bundles the three handshake groups around the SIMD issue controller:
//     op_*  : instruction from the core (valid/ready, funct, rs1, rs2, rd)
//     vu_*  : operand/strobe bus to the packed-SIMD unit and its response
//     wb_*  : writeback to the core (valid/ready, rd, data, err)
//   modport master : the issue controller
//   modport slave  : the environment (core + SIMD unit)
// ---------------------------------------------------------------------------
interface simd_issue_ctrl_if;
  // core -> controller
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_funct;
  logic [31:0] op_rs1;
  logic [31:0] op_rs2;
  logic [4:0]  op_rd;
  // controller <-> SIMD unit
  logic [1:0]  vu_ctrl;
  logic [31:0] vu_a;
  logic [31:0] vu_b;
  logic        vu_valid_in;
  logic        vu_valid_out;
  logic [31:0] vu_result;
  // controller -> core writeback
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  modport master (
    input  op_valid, op_funct, op_rs1, op_rs2, op_rd,
    output op_ready,
    output vu_ctrl, vu_a, vu_b, vu_valid_in,
    input  vu_valid_out, vu_result,
    output wb_valid, wb_rd, wb_data, wb_err,
    input  wb_ready
  );

  modport slave (
    output op_valid, op_funct, op_rs1, op_rs2, op_rd,
    input  op_ready,
    input  vu_ctrl, vu_a, vu_b, vu_valid_in,
    output vu_valid_out, vu_result,
    input  wb_valid, wb_rd, wb_data, wb_err,
    output wb_ready
  );
endinterface

// File: rtl/simd_issue_ctrl.sv
// ---------------------------------------------------------------------------
// simd_issue_ctrl
//   Issue-side controller for the packed-SIMD unit. Accepts one instruction
//   at a time, pulses the unit's valid_in, holds operands until the unit
//   answers, then hands the result to the core's writeback port. A wait
//   timer guards against a hung unit; expiry returns an error writeback and
//   latches a sticky fault that only reset clears.
//
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : simd_issue_ctrl_if.master (op_*, vu_*, wb_* groups)
//     fault    : sticky timeout fault
//     done_cnt : successful completions, saturating at 0xFFFF
//
//   Parameter:
//     TIMEOUT  : max cycles spent waiting for the unit (8..255)
// ---------------------------------------------------------------------------
module simd_issue_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  simd_issue_ctrl_if.master        bus,
  output logic                     fault,
  output logic [15:0]              done_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Timer value in the last permitted WAIT cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;

  // Issue registers: written only on an IDLE accept so the unit sees stable
  // operands for the whole computation.
  logic [1:0]  r_funct;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;

  logic [7:0]  r_timer;
  logic [31:0] r_wb_data;
  logic        r_wb_err;
  logic        r_fault;
  logic [15:0] r_done_cnt;

  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;
  logic        w_drive_vu;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and FSM-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_capture       = 1'b0;
    w_timeout       = 1'b0;
    bus.op_ready    = 1'b0;
    bus.vu_valid_in = 1'b0;
    bus.wb_valid    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        bus.vu_valid_in = 1'b1;
        w_state_next    = ST_WAIT;
      end

      ST_WAIT: begin
        // A response in the final timer cycle still counts as success.
        if (bus.vu_valid_out) begin
          w_capture    = 1'b1;
          w_state_next = (r_rd != 5'd0) ? ST_RESP : ST_IDLE;
        end else if (r_timer == TMO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) begin
          w_state_next = r_wb_err ? ST_FAULT : ST_IDLE;
        end
      end

      ST_FAULT: begin
        w_state_next = ST_FAULT;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct    <= 2'd0;
      r_rs1      <= 32'd0;
      r_rs2      <= 32'd0;
      r_rd       <= 5'd0;
      r_timer    <= 8'd0;
      r_wb_data  <= 32'd0;
      r_wb_err   <= 1'b0;
      r_fault    <= 1'b0;
      r_done_cnt <= 16'd0;
    end else begin
      if (w_accept) begin
        r_funct <= bus.op_funct;
        r_rs1   <= bus.op_rs1;
        r_rs2   <= bus.op_rs2;
        r_rd    <= bus.op_rd;
      end

      if (r_state == ST_ISSUE) begin
        r_timer <= 8'd0;
      end else if (r_state == ST_WAIT) begin
        r_timer <= r_timer + 8'd1;
      end

      if (w_capture) begin
        r_wb_data <= bus.vu_result;
        r_wb_err  <= 1'b0;
        if (r_done_cnt != 16'hFFFF) begin
          r_done_cnt <= r_done_cnt + 16'd1;
        end
      end

      if (w_timeout) begin
        r_wb_data <= 32'd0;
        r_wb_err  <= 1'b1;
        r_fault   <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output drive: the unit bus is forced quiet once faulted.
  // -------------------------------------------------------------------------
  assign w_drive_vu  = (r_state != ST_FAULT);
  assign bus.vu_ctrl = w_drive_vu ? r_funct : 2'd0;
  assign bus.vu_a    = w_drive_vu ? r_rs1   : 32'd0;
  assign bus.vu_b    = w_drive_vu ? r_rs2   : 32'd0;

  assign bus.wb_rd   = r_rd;
  assign bus.wb_data = r_wb_data;
  assign bus.wb_err  = r_wb_err;

  assign fault       = r_fault;
  assign done_cnt    = r_done_cnt;

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simd_issue_ctrl
//   Drives simd_issue_ctrl with directed and randomized instructions against
//   a behavioural SIMD unit and a reference model of lane arithmetic and
//   handshake timing. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_simd_issue_ctrl;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        fault;
  logic [15:0] done_cnt;
  logic        hang;
  logic [2:0]  u_cnt;
  int          cyc;
  int          n_checks;
  int          n_errors;
  int          model_done;

  simd_issue_ctrl_if bus ();

  simd_issue_ctrl #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fault    (fault),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Lane arithmetic: signed bytes; PVADD wraps per byte, PVMUL/UPPER give
  // two 16-bit products of bytes 0,1 or 2,3, PVMAC sums all four products.
  function automatic logic [31:0] simd_model(input logic [1:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    int acc;
    int sa;
    int sb;
    int lane;
    r   = 32'd0;
    acc = 0;
    case (f)
      2'b00: begin
        for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
      end
      2'b01, 2'b11: begin
        for (int i = 0; i < 2; i++) begin
          lane = (f == 2'b11) ? i + 2 : i;
          sa = int'($signed(a[8*lane +: 8]));
          sb = int'($signed(b[8*lane +: 8]));
          r[16*i +: 16] = 16'(sa * sb);
        end
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          sa = int'($signed(a[8*i +: 8]));
          sb = int'($signed(b[8*i +: 8]));
          acc = acc + sa * sb;
        end
        r = 32'(acc);
      end
    endcase
    return r;
  endfunction

  function automatic logic [2:0] unit_lat(input logic [1:0] f);
    case (f)
      2'b00:   return 3'd2;
      2'b10:   return 3'd6;
      default: return 3'd5;
    endcase
  endfunction

  // Behavioural SIMD unit: reads operands combinationally, answers a fixed
  // number of cycles after valid_in, or never when hang is set.
  assign bus.vu_result = simd_model(bus.vu_ctrl, bus.vu_a, bus.vu_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cnt            <= 3'd0;
      bus.vu_valid_out <= 1'b0;
    end else begin
      bus.vu_valid_out <= 1'b0;
      if (bus.vu_valid_in) begin
        u_cnt <= unit_lat(bus.vu_ctrl) - 3'd1;
      end else if (u_cnt != 3'd0) begin
        u_cnt <= u_cnt - 3'd1;
        if (u_cnt == 3'd1 && !hang) bus.vu_valid_out <= 1'b1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_op_ready"},    32'(bus.op_ready),    32'd1);
    check_val({pfx, "_vu_ctrl"},     32'(bus.vu_ctrl),     32'd0);
    check_val({pfx, "_vu_a"},        bus.vu_a,             32'd0);
    check_val({pfx, "_vu_b"},        bus.vu_b,             32'd0);
    check_val({pfx, "_vu_valid_in"}, 32'(bus.vu_valid_in), 32'd0);
    check_val({pfx, "_wb_valid"},    32'(bus.wb_valid),    32'd0);
    check_val({pfx, "_wb_rd"},       32'(bus.wb_rd),       32'd0);
    check_val({pfx, "_wb_data"},     bus.wb_data,          32'd0);
    check_val({pfx, "_wb_err"},      32'(bus.wb_err),      32'd0);
    check_val({pfx, "_fault"},       32'(fault),           32'd0);
    check_val({pfx, "_done_cnt"},    32'(done_cnt),        32'd0);
  endtask

  task automatic drive_junk_op();
    bus.op_valid = 1'($urandom_range(0, 1));
    bus.op_funct = 2'($urandom_range(0, 3));
    bus.op_rs1   = $urandom;
    bus.op_rs2   = $urandom;
    bus.op_rd    = 5'($urandom_range(0, 31));
  endtask

  // Issue one instruction from an IDLE negedge; returns at an IDLE negedge.
  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int bp, input logic [31:0] exp_data);
    int   t_acc;
    int   n;
    int   n_end;
    int   n_vin;
    int   vin_cnt;
    int   exp_lat;
    logic any_wb;
    logic ops_ok;
    logic hold_ok;

    exp_lat = (f == 2'b00) ? 4 : (f == 2'b10) ? 8 : 7;
    check_val("accept_ready", 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1;
    bus.op_funct = f;
    bus.op_rs1   = a;
    bus.op_rs2   = b;
    bus.op_rd    = rd;
    bus.wb_ready = (bp == 0);
    t_acc   = cyc;
    n_end   = -1;
    n_vin   = -1;
    vin_cnt = 0;
    any_wb  = 1'b0;
    ops_ok  = 1'b1;

    for (int k = 1; k <= 40 && n_end < 0; k++) begin
      @(negedge clk);
      n = cyc - t_acc;
      if (bus.vu_valid_in) begin
        vin_cnt++;
        n_vin = n;
      end
      if (bus.wb_valid) any_wb = 1'b1;
      if (bus.wb_valid || bus.op_ready) begin
        n_end = n;
      end else begin
        if (bus.vu_ctrl !== f || bus.vu_a !== a || bus.vu_b !== b) ops_ok = 1'b0;
        drive_junk_op();
      end
    end
    bus.op_valid = 1'b0;

    check_val("latency",         32'(n_end),   32'(exp_lat));
    check_val("vin_cycle",       32'(n_vin),   32'd1);
    check_val("vin_pulses",      32'(vin_cnt), 32'd1);
    check_val("operands_stable", 32'(ops_ok),  32'd1);

    if (rd != 5'd0) begin
      check_val("wb_valid", 32'(any_wb),     32'd1);
      check_val("wb_rd",    32'(bus.wb_rd),  32'(rd));
      check_val("wb_data",  bus.wb_data,     exp_data);
      check_val("wb_err",   32'(bus.wb_err), 32'd0);
      hold_ok = 1'b1;
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        if (!(bus.wb_valid === 1'b1 && bus.wb_rd === rd && bus.wb_data === exp_data &&
              bus.wb_err === 1'b0 && bus.op_ready === 1'b0)) hold_ok = 1'b0;
        drive_junk_op();
      end
      if (bp > 0) check_val("backpressure_hold", 32'(hold_ok), 32'd1);
      bus.op_valid = 1'b0;
      bus.wb_ready = 1'b1;
      @(negedge clk);
      check_val("ready_after_wb", 32'(bus.op_ready), 32'd1);
      check_val("wb_dropped",     32'(bus.wb_valid), 32'd0);
    end else begin
      check_val("no_wb_rd0", 32'(any_wb), 32'd0);
    end

    if (model_done < 16'hFFFF) model_done++;
    check_val("done_cnt", 32'(done_cnt), 32'(model_done));
    $display("op funct=%0d rs1=%08h rs2=%08h rd=%0d bp=%0d lat=%0d wb_data=%08h done=%0d",
             f, a, b, rd, bp, n_end, bus.wb_data, done_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_acc;
    int          n_end;
    int          vin_cnt;
    logic        stuck_ok;
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;

    n_checks     = 0;
    n_errors     = 0;
    model_done   = 0;
    cyc          = 0;
    hang         = 1'b0;
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_funct = 2'd0;
    bus.op_rs1   = 32'd0;
    bus.op_rs2   = 32'd0;
    bus.op_rd    = 5'd0;
    bus.wb_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations with hand-computed results.
    do_op(2'b00, 32'h7F01FF80, 32'h01010180, 5'd5, 0, 32'h80020000);
    do_op(2'b01, 32'h0000FE03, 32'h00000504, 5'd9, 0, 32'hFFF6000C);
    do_op(2'b10, 32'h01020304, 32'h01010101, 5'd3, 0, 32'h0000000A);
    do_op(2'b11, 32'hFE030000, 32'h05040000, 5'd4, 0, 32'hFFF6000C);
    do_op(2'b00, 32'h11223344, 32'h01010101, 5'd12, 5, 32'h12233445);
    do_op(2'b00, 32'h01010101, 32'h01010101, 5'd0, 0, 32'h02020202);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      f  = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(f, a, b, rd, int'($urandom_range(0, 3)), simd_model(f, a, b));
    end

    // Hung unit: timeout, error writeback, sticky fault.
    hang = 1'b1;
    check_val("to_accept_ready", 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1;
    bus.op_funct = 2'b01;
    bus.op_rs1   = $urandom;
    bus.op_rs2   = $urandom;
    bus.op_rd    = 5'd7;
    bus.wb_ready = 1'b1;
    t_acc   = cyc;
    n_end   = -1;
    vin_cnt = 0;
    for (int k = 1; k <= 60 && n_end < 0; k++) begin
      @(negedge clk);
      bus.op_valid = 1'b0;
      if (bus.vu_valid_in) vin_cnt++;
      if (bus.wb_valid) n_end = cyc - t_acc;
    end
    check_val("to_latency",  32'(n_end),       32'(TMO + 2));
    check_val("to_vin",      32'(vin_cnt),     32'd1);
    check_val("to_wb_err",   32'(bus.wb_err),  32'd1);
    check_val("to_wb_data",  bus.wb_data,      32'd0);
    check_val("to_wb_rd",    32'(bus.wb_rd),   32'd7);
    check_val("to_fault",    32'(fault),       32'd1);
    check_val("to_done_cnt", 32'(done_cnt),    32'(model_done));
    $display("op timeout rd=7 lat=%0d wb_err=%0d fault=%0d", n_end, bus.wb_err, fault);

    @(negedge clk);
    check_val("fault_wb_dropped", 32'(bus.wb_valid), 32'd0);
    check_val("fault_op_ready",   32'(bus.op_ready), 32'd0);
    stuck_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_junk_op();
      @(negedge clk);
      if (!(bus.op_ready === 1'b0 && bus.vu_valid_in === 1'b0 && bus.vu_a === 32'd0 &&
            bus.vu_b === 32'd0 && bus.vu_ctrl === 2'd0 && bus.wb_valid === 1'b0 &&
            fault === 1'b1)) stuck_ok = 1'b0;
    end
    check_val("fault_sticky", 32'(stuck_ok), 32'd1);

    // Asynchronous reset out of FAULT.
    bus.op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("fault_reset");
    @(negedge clk);
    rst_n      = 1'b1;
    hang       = 1'b0;
    model_done = 0;
    @(negedge clk);
    do_op(2'b10, 32'h01020304, 32'h01010101, 5'd3, 0, 32'h0000000A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
